main_control_fsm: RTL

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/main_control_outdec.sv | 101 ++++++++++
 rtl/main_control_fsm.sv | 63 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared control state encodings, opcode constants and alu_op codes
package mips_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_I_EXEC  = 4'd9,
    S_I_WB    = 4'd10,
    S_JUMP    = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [2:0] ALU_I   = 3'd0;
  localparam logic [2:0] ALU_MEM = 3'd1;
  localparam logic [2:0] ALU_BR  = 3'd2;
  localparam logic [2:0] ALU_R   = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd4;
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_R:                                      decode_next = S_R_EXEC;
      OP_LW, OP_SW:                              decode_next = S_MEM_ADR;
      OP_BEQ, OP_BNE:                            decode_next = S_BRANCH;
      OP_J:                                      decode_next = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: decode_next = S_I_EXEC;
      default:                                   decode_next = S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/main_control_outdec.sv
// main_control_outdec: maps state, opcode, zero and ready to control outputs
module main_control_outdec
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        rdy,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        instr_done
);
  always_comb begin
    alu_op = ALU_I;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    pc_src = 2'd0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    pc_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'd1;
        alu_op = ALU_ADD;
        ir_write = rdy;
        pc_write = rdy;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op = ALU_ADD;
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op = ALU_MEM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord = 1'b1;
        instr_done = rdy;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = ALU_R;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_BR;
        pc_src = 2'd1;
        pc_write = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op = ALU_I;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src = 2'd2;
        pc_write = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle MIPS main control state machine
module main_control_fsm
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        instr_done,
  output logic [3:0]  state
);
  state_t cur;
  logic rdy, m_rd, m_wr, ir_w, rg_w, pc_w, done;
  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  main_control_outdec u_outdec (
    .state(cur), .opcode(opcode), .zero(zero), .rdy(rdy),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .iord(iord), .mem_read(m_rd), .mem_write(m_wr),
    .ir_write(ir_w), .reg_write(rg_w), .pc_write(pc_w), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      case (cur)
        S_FETCH:   cur <= rdy ? S_DECODE : S_FETCH;
        S_DECODE:  cur <= decode_next(opcode);
        S_MEM_ADR: cur <= opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  cur <= rdy ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:  cur <= rdy ? S_FETCH : S_MEM_WR;
        S_R_EXEC:  cur <= S_R_WB;
        S_I_EXEC:  cur <= S_I_WB;
        default:   cur <= S_FETCH;
      endcase
      if (cur == S_DECODE && decode_next(opcode) == S_FETCH) illegal <= 1'b1;
    end
  end
  assign state = cur;
  assign mem_read = m_rd & ~rst;
  assign mem_write = m_wr & ~rst;
  assign ir_write = ir_w & ~rst;
  assign reg_write = rg_w & ~rst;
  assign pc_write = pc_w & ~rst;
  assign instr_done = done & ~rst;
endmodule
